sliding_window_gen: RTL and testbench
=====================================

Name: sliding_window_gen

Overview:
- Sits directly downstream of the line-buffer FIFO chain.
- Takes the current pixel plus the K-1 vertically aligned pixels read out of the line-buffer FIFOs, and shifts them into a KxK register window.
- Tracks column and row position, and emits one registered KxK window per legal kernel position under valid/ready flow control.
- Feeds the gradient stage.

Parameters:
- DATA_WIDTH, 8, pixel width in bits.
- IMG_WIDTH, 854, pixels per line; must equal the line-buffer FIFO depth.
- IMG_HEIGHT, 480, lines per frame.
- KERNEL_WIDTH, 3, window side K; legal range 2..7.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- in_data  in  DATA_WIDTH  current-line pixel.
- taps_data  in  (K-1)*DATA_WIDTH  line-buffer outputs; slice i holds the pixel i+1 lines above in_data.
- in_sof  in  1  start of frame; qualified by an accepted beat.
- in_valid  in  1  in_data/taps_data/in_sof valid.
- in_ready  out  1  block accepts a beat; drives r_ready of the line buffer.
- window_data  out  K*K*DATA_WIDTH  element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]; r=0 is the top (oldest) line, c=0 is the leftmost (oldest) column.
- window_valid  out  1  window_data valid.
- window_ready  in  1  consumer accepts the window.
- window_border  out  1  window overlaps the left image edge (see Optional Feature).
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted.

Behaviour:
- Reset values: window_data=0, window_valid=0, window_border=0, frame_done=0. Internal state cleared: col=0, row=0, shift registers=0.
- Accept: accept = in_valid && in_ready, where in_ready = ~window_valid || window_ready. This is a single output stage allowing full throughput; in_ready is combinational from window_ready.
- Shift on accept:
  - each window row shifts left by one column;
  - the new column enters at c=K-1: row K-1 <= in_data; row K-2-i <= taps_data slice i.
- Position counters:
  - col increments on each accept and wraps IMG_WIDTH-1 -> 0, incrementing row at the wrap.
  - row wraps IMG_HEIGHT-1 -> 0.
  - An accepted beat with in_sof=1 is treated as position (0,0); the counters then advance from there, discarding any partial frame.
- Emit condition, evaluated on the accepted pixel's position (before increment): emit = row >= K-1 && col >= K-1.
- Output register:
  - On accept with emit, window_valid <= 1 one cycle later and window_data holds the post-shift window. Latency is 1 cycle from the completing accept.
  - On window_valid && window_ready with no new emit, window_valid <= 0.
  - Simultaneous drain and new emit: window_valid stays 1 and the data updates, with no bubble.
- Stall: window_valid && ~window_ready forces in_ready=0. window_data and window_valid are held stable, and the shift registers and counters are frozen.
- Horizontal border: columns 0..K-2 of each line shift data in but emit nothing. The stale previous-line columns are flushed by K-1 shifts before the first emit.
- frame_done: asserted the cycle after accepting (row,col) = (IMG_HEIGHT-1, IMG_WIDTH-1); coincides with the last window_valid rise.
- Reset mid-frame: asynchronous clear of everything listed above. The next frame must start with in_sof or from a freshly reset line buffer.
- Widths:
  - col: $clog2(IMG_WIDTH) bits.
  - row: $clog2(IMG_HEIGHT) bits.
  - No arithmetic on pixel data.

Optional Feature:
- Macro: SLIDING_WINDOW_BORDER_OUT_EN.
- Without the macro: only interior windows are emitted; window_border is tied to 0.
- With the macro:
  - emit = row >= K-1, so every accepted pixel of an eligible row produces a window;
  - window_border=1 when col < K-1, registered with window_data;
  - the consumer must zero its result for border windows.
- The stall, latency and frame_done rules are unchanged in both cases.

Decomposition:
- Package line_buffer_pkg holds:
  - IMG_WIDTH and IMG_HEIGHT defaults;
  - the KERNEL_WIDTH default;
  - a function win_idx(r,c) returning the window_data bit offset.
- Sub-module window_pos_counter holds the col/row counters, the sof reload, the emit/border decode and frame_done.
- The shift array and output register stay in the top module.

Test Plan:
- Raster fill (IMG_WIDTH=5, IMG_HEIGHT=4, K=3):
  - Stimulus: pixels 0..19 with taps = pixel-5 and pixel-10, window_ready=1, continuous valid.
  - Required: exactly 6 windows. The first follows the pixel 12 accept by 1 cycle, with rows {0,1,2},{5,6,7},{10,11,12}. frame_done pulses once after pixel 19.
- Backpressure:
  - Stimulus: window_ready=0 for 4 cycles during the second window.
  - Required: in_ready=0, window_data stable ({1,2,3},{6,7,8},{11,12,13}), no beats lost. The order of the remaining windows is unchanged.
- Full throughput with random gaps:
  - Stimulus: random in_valid gaps and window_ready toggling.
  - Required: output window sequence identical to the scoreboard; no window duplicated or dropped.
- Mid-frame sof:
  - Stimulus: in_sof asserted at pixel 8 of a frame.
  - Required: counters restart at (0,0). The first emit is after the 13th beat counted from the sof beat.
- Async reset while window_valid=1 and ready stalled:
  - Required: window_valid=0 and frame_done=0 immediately, without waiting for a clock edge. The next frame yields the same 6 windows as the first scenario.
- SLIDING_WINDOW_BORDER_OUT_EN defined, same stimulus as the first scenario:
  - Required: 10 windows; window_border=1 exactly on those at col 0 and 1.

Source files
------------

// File: rtl/line_buffer_pkg.sv
// Shared defaults and window addressing for the line-buffer / sliding-window datapath.
package line_buffer_pkg;

    localparam int DATA_WIDTH_DEF   = 8;
    localparam int IMG_WIDTH_DEF    = 854;
    localparam int IMG_HEIGHT_DEF   = 480;
    localparam int KERNEL_WIDTH_DEF = 3;

    // Bit offset of window element (r,c); r=0 is the oldest line, c=0 the oldest column.
    function automatic int win_idx(input int r, input int c, input int k, input int dw);
        return (r * k + c) * dw;
    endfunction

endpackage

// File: rtl/window_pos_counter.sv
// Column/row position tracking, sof reload, emit/border decode and frame_done pulse.
// Border windows are emitted only when SLIDING_WINDOW_BORDER_OUT_EN is defined.
module window_pos_counter
    import line_buffer_pkg::*;
#(
    parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT   = IMG_HEIGHT_DEF,
    parameter int KERNEL_WIDTH = KERNEL_WIDTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic accept,
    input  logic sof,
    output logic emit,
    output logic border,
    output logic frame_done
);

    localparam int COL_W = $clog2(IMG_WIDTH);
    localparam int ROW_W = $clog2(IMG_HEIGHT);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_KM1  = COL_W'(KERNEL_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_KM1  = ROW_W'(KERNEL_WIDTH - 1);

    logic [COL_W-1:0] col_r;
    logic [ROW_W-1:0] row_r;
    logic [COL_W-1:0] cur_col_s;
    logic [ROW_W-1:0] cur_row_s;
    logic [COL_W-1:0] col_nxt_s;
    logic [ROW_W-1:0] row_nxt_s;
    logic             last_s;
    logic             frame_done_r;

    // Position of the beat being accepted (sof forces 0,0) and the position that follows it.
    always_comb begin
        cur_col_s = sof ? {COL_W{1'b0}} : col_r;
        cur_row_s = sof ? {ROW_W{1'b0}} : row_r;
        col_nxt_s = cur_col_s;
        row_nxt_s = cur_row_s;
        if (cur_col_s == COL_LAST) begin
            col_nxt_s = {COL_W{1'b0}};
            if (cur_row_s == ROW_LAST) begin
                row_nxt_s = {ROW_W{1'b0}};
            end else begin
                row_nxt_s = cur_row_s + {{(ROW_W-1){1'b0}}, 1'b1};
            end
        end else begin
            col_nxt_s = cur_col_s + {{(COL_W-1){1'b0}}, 1'b1};
        end
        last_s = (cur_col_s == COL_LAST) && (cur_row_s == ROW_LAST);
    end

    // Emit/border decode on the accepted beat's position, before it advances.
    always_comb begin
`ifdef SLIDING_WINDOW_BORDER_OUT_EN
        emit   = (cur_row_s >= ROW_KM1);
        border = (cur_col_s < COL_KM1);
`else
        emit   = (cur_row_s >= ROW_KM1) && (cur_col_s >= COL_KM1);
        border = 1'b0;
`endif
    end

    // Position counters advance only on accepted beats.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= {COL_W{1'b0}};
            row_r <= {ROW_W{1'b0}};
        end else if (accept) begin
            col_r <= col_nxt_s;
            row_r <= row_nxt_s;
        end
    end

    // One-cycle pulse after the last pixel of a frame is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= accept && last_s;
        end
    end

    assign frame_done = frame_done_r;

endmodule

// File: rtl/sliding_window_gen.sv
// KxK sliding window generator fed by the line-buffer FIFO taps, with a single output stage.
// Optional macro SLIDING_WINDOW_BORDER_OUT_EN also emits left-edge windows flagged by window_border.
module sliding_window_gen
    import line_buffer_pkg::*;
#(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int IMG_WIDTH    = IMG_WIDTH_DEF,
    parameter int IMG_HEIGHT   = IMG_HEIGHT_DEF,
    parameter int KERNEL_WIDTH = KERNEL_WIDTH_DEF
) (
    input  logic                                             clk,
    input  logic                                             rst,
    input  logic [DATA_WIDTH-1:0]                            in_data,
    input  logic [(KERNEL_WIDTH-1)*DATA_WIDTH-1:0]           taps_data,
    input  logic                                             in_sof,
    input  logic                                             in_valid,
    output logic                                             in_ready,
    output logic [KERNEL_WIDTH*KERNEL_WIDTH*DATA_WIDTH-1:0]  window_data,
    output logic                                             window_valid,
    input  logic                                             window_ready,
    output logic                                             window_border,
    output logic                                             frame_done
);

    localparam int K  = KERNEL_WIDTH;
    localparam int DW = DATA_WIDTH;
    localparam int WW = K * K * DW;

    logic [WW-1:0] shift_r;
    logic [WW-1:0] shifted_s;
    logic [WW-1:0] window_data_r;
    logic          window_valid_r;
    logic          window_border_r;
    logic          in_ready_s;
    logic          accept_s;
    logic          emit_s;
    logic          border_s;

    assign in_ready_s = ~window_valid_r | window_ready;
    assign accept_s   = in_valid & in_ready_s;

    window_pos_counter #(
        .IMG_WIDTH    (IMG_WIDTH),
        .IMG_HEIGHT   (IMG_HEIGHT),
        .KERNEL_WIDTH (KERNEL_WIDTH)
    ) u_pos (
        .clk        (clk),
        .rst        (rst),
        .accept     (accept_s),
        .sof        (in_sof),
        .emit       (emit_s),
        .border     (border_s),
        .frame_done (frame_done)
    );

    // Window after one shift: every row moves left, the new column enters at c=K-1.
    always_comb begin
        shifted_s = {WW{1'b0}};
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                if (c < K - 1) begin
                    shifted_s[win_idx(r, c, K, DW) +: DW] = shift_r[win_idx(r, c + 1, K, DW) +: DW];
                end else if (r == K - 1) begin
                    shifted_s[win_idx(r, c, K, DW) +: DW] = in_data;
                end else begin
                    shifted_s[win_idx(r, c, K, DW) +: DW] = taps_data[(K - 2 - r) * DW +: DW];
                end
            end
        end
    end

    // Shift array; frozen while the output stage is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= {WW{1'b0}};
        end else if (accept_s) begin
            shift_r <= shifted_s;
        end
    end

    // Output stage: load on emit (also while draining, so no bubble), clear on drain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            window_data_r   <= {WW{1'b0}};
            window_valid_r  <= 1'b0;
            window_border_r <= 1'b0;
        end else if (accept_s && emit_s) begin
            window_data_r   <= shifted_s;
            window_valid_r  <= 1'b1;
            window_border_r <= border_s;
        end else if (window_ready) begin
            window_valid_r  <= 1'b0;
        end
    end

    assign in_ready      = in_ready_s;
    assign window_data   = window_data_r;
    assign window_valid  = window_valid_r;
    assign window_border = window_border_r;

endmodule

// File: tb/tb_sliding_window_gen.sv
// Self-checking bench for sliding_window_gen on a 5x4 image with a 3x3 kernel.
module tb_sliding_window_gen;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int K  = 3;
    localparam int WW = K * K * DW;
`ifdef SLIDING_WINDOW_BORDER_OUT_EN
    localparam bit BORDER = 1'b1;
`else
    localparam bit BORDER = 1'b0;
`endif
    // Hand-derived: interior-only gives 2x3 windows, first at frame beat 13 (pixel 12);
    // with border windows every pixel of rows 2..3 emits, first at beat 11 (pixel 10).
    localparam int EXP_WIN   = BORDER ? 10 : 6;
    localparam int EXP_FIRST = BORDER ? 11 : 13;

    logic                clk;
    logic                rst;
    logic [DW-1:0]       in_data;
    logic [(K-1)*DW-1:0] taps_data;
    logic                in_sof;
    logic                in_valid;
    logic                in_ready;
    logic [WW-1:0]       window_data;
    logic                window_valid;
    logic                window_ready;
    logic                window_border;
    logic                frame_done;

    sliding_window_gen #(
        .DATA_WIDTH   (DW),
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H),
        .KERNEL_WIDTH (K)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .taps_data     (taps_data),
        .in_sof        (in_sof),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .window_data   (window_data),
        .window_valid  (window_valid),
        .window_ready  (window_ready),
        .window_border (window_border),
        .frame_done    (frame_done)
    );

    typedef struct {
        logic [WW-1:0] d;
        logic          b;
    } win_t;

    typedef struct {
        int nbeats;
        int sof_at;
        bit gaps;
        bit rnd;
        int exp_win;
        int exp_first;
        int exp_fd;
    } scn_t;

    int   n_vec = 0;
    int   n_err = 0;
    win_t exp_q[$];
    win_t mon_w;
    scn_t tbl[3];
    bit   rnd_mode;

    int            m_col, m_row, since_sof, first_emit, n_win, n_fd, cc, rr;
    bit            lat_pend, fd_exp, prev_valid, prev_ready, em;
    logic [WW-1:0] lat_d, prev_d, w2;
    logic          lat_b;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // Expected window for a stream where taps carry the values W and 2W beats earlier.
    function automatic logic [WW-1:0] mk_win(input logic [DW-1:0] g);
        logic [WW-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[(r*K+c)*DW +: DW] = g - DW'((K-1-r)*W + (K-1-c));
        return w;
    endfunction

    always @(posedge clk) begin
        #1;
        if (rnd_mode) window_ready = 1'($urandom_range(0, 1));
    end

    // Monitor and scoreboard, sampling on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            m_col = 0; m_row = 0; since_sof = 0;
            lat_pend = 0; fd_exp = 0; prev_valid = 0; prev_ready = 1;
        end else begin
            chk("in_ready", 128'(in_ready), 128'(!window_valid || window_ready));
            if (lat_pend) begin
                chk("latency_valid", 128'(window_valid), 128'(1));
                chk("latency_data", 128'(window_data), 128'(lat_d));
                chk("latency_border", 128'(window_border), 128'(lat_b));
                lat_pend = 0;
            end
            if (window_valid && prev_valid && !prev_ready)
                chk("stall_hold", 128'(window_data), 128'(prev_d));
            if (frame_done || fd_exp) chk("frame_done", 128'(frame_done), 128'(fd_exp));
            if (frame_done) n_fd++;
            fd_exp = 0;
            if (window_valid && window_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL spurious_window: got %h, required none", window_data);
                end else begin
                    mon_w = exp_q.pop_front();
                    chk("window_data", 128'(window_data), 128'(mon_w.d));
                    chk("window_border", 128'(window_border), 128'(mon_w.b));
                end
                n_win++;
            end
            prev_valid = window_valid; prev_ready = window_ready; prev_d = window_data;
            if (in_valid && in_ready) begin
                cc = in_sof ? 0 : m_col;
                rr = in_sof ? 0 : m_row;
                since_sof = in_sof ? 1 : since_sof + 1;
                em = (rr >= K-1) && (BORDER || cc >= K-1);
                if (em) begin
                    mon_w.d = mk_win(in_data);
                    mon_w.b = BORDER && (cc < K-1);
                    exp_q.push_back(mon_w);
                    lat_pend = 1; lat_d = mon_w.d; lat_b = mon_w.b;
                    if (first_emit < 0) first_emit = since_sof;
                end
                fd_exp = (rr == H-1) && (cc == W-1);
                m_row = (cc == W-1) ? ((rr == H-1) ? 0 : rr + 1) : rr;
                m_col = (cc == W-1) ? 0 : cc + 1;
            end
        end
    end

    task automatic send(input int b, input bit sof);
        int cyc;
        bit took;
        in_data = DW'(b);
        taps_data = {DW'(b - 2*W), DW'(b - W)};
        in_sof = sof;
        in_valid = 1'b1;
        cyc = 0; took = 0;
        while (!took && cyc < 200) begin
            @(negedge clk); took = in_ready;
            @(posedge clk); #1; cyc++;
        end
        if (!took) begin
            n_vec++; n_err++;
            $display("FAIL send_timeout beat %0d: in_ready got 0, required 1", b);
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0;
        #1;
        chk("reset_valid", 128'(window_valid), 128'(0));
        chk("reset_data", 128'(window_data), 128'(0));
        chk("reset_border", 128'(window_border), 128'(0));
        chk("reset_frame_done", 128'(frame_done), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        n_win = 0; n_fd = 0; first_emit = -1;
    endtask

    task automatic drain_and_check(input int exp_win, input int exp_first, input int exp_fd);
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 300) begin
            @(posedge clk); #1; cyc++;
        end
        rnd_mode = 0; window_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("window_count", 128'(n_win), 128'(exp_win));
        chk("frame_done_count", 128'(n_fd), 128'(exp_fd));
        chk("first_emit_beat", 128'(first_emit), 128'(exp_first));
        chk("leftover_windows", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic run_scn(input scn_t s);
        do_reset();
        window_ready = 1'b1;
        rnd_mode = s.rnd;
        for (int b = 0; b < s.nbeats; b++) begin
            send(b, (b == 0) || (b == s.sof_at));
            if (s.gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        drain_and_check(s.exp_win, s.exp_first, s.exp_fd);
    endtask

    initial begin
        int v2[9];
        clk = 1'b0; rst = 1'b1; in_data = '0; taps_data = '0; in_sof = 1'b0;
        in_valid = 1'b0; window_ready = 1'b1; rnd_mode = 0;
        v2 = '{1, 2, 3, 6, 7, 8, 11, 12, 13};
        for (int i = 0; i < 9; i++) w2[i*DW +: DW] = DW'(v2[i]);

        // nbeats, sof_at, gaps, random ready, windows, first-emit beat, frame_done pulses
        tbl[0] = '{20, -1, 1'b0, 1'b0, EXP_WIN, EXP_FIRST, 1};
        tbl[1] = '{20, -1, 1'b1, 1'b1, EXP_WIN, EXP_FIRST, 1};
        tbl[2] = '{28,  8, 1'b0, 1'b0, EXP_WIN, EXP_FIRST, 1};
        for (int i = 0; i < 3; i++) run_scn(tbl[i]);

        // Backpressure: hold window_ready low for 4 cycles on the window completed by pixel 13.
        do_reset();
        window_ready = 1'b1;
        fork
            begin
                for (int b = 0; b < W*H; b++) send(b, b == 0);
            end
            begin
                int cyc;
                cyc = 0;
                while (!(window_valid && window_data[DW-1:0] == 8'd0) && cyc < 300) begin
                    @(negedge clk); cyc++;
                end
                chk("bp_wait", 128'(cyc < 300), 128'(1));
                @(posedge clk); #1; window_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("bp_in_ready", 128'(in_ready), 128'(0));
                    chk("bp_valid", 128'(window_valid), 128'(1));
                    chk("bp_data", 128'(window_data), 128'(w2));
                end
                @(posedge clk); #1; window_ready = 1'b1;
            end
        join
        drain_and_check(EXP_WIN, EXP_FIRST, 1);

        // Asynchronous reset while a window is held by a stalled consumer.
        do_reset();
        window_ready = 1'b0;
        for (int b = 0; b < EXP_FIRST; b++) send(b, b == 0);
        chk("ar_valid_before", 128'(window_valid), 128'(1));
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 128'(window_valid), 128'(0));
        chk("ar_frame_done", 128'(frame_done), 128'(0));
        chk("ar_data", 128'(window_data), 128'(0));
        @(posedge clk); #1 rst = 1'b0;
        run_scn(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
